fifo_push_arbiter: RTL and testbench

//  Shares the push side of the single-clock FIFO (fifo + sdp_dc_ram) among N_REQ producers.

---
 rtl/fifo_push_arbiter_pkg.sv | 16 +
 rtl/sdp_dc_ram_pkg.sv | 4 +
 rtl/fifo_push_arbiter_if.sv | 25 ++
 rtl/fifo_push_arbiter_rr_select.sv | 24 ++
 rtl/fifo_push_arbiter.sv | 114 +++++++++++
 tb/tb_fifo_push_arbiter.sv | 127 ++++++++++++
 6 files changed

// File: rtl/fifo_push_arbiter_pkg.sv
// Types and limits shared by the FIFO push arbiter, its selector and interface.
package fifo_arb_pkg;
    import sdp_dc_ram_pkg::*;

    localparam int N_REQ_MAX     = 8;
    localparam int BURST_LEN_MAX = 16;
    localparam int BURST_W       = $clog2(BURST_LEN_MAX + 1);
    localparam int IDX_W         = $clog2(N_REQ_MAX);

    typedef enum logic {
        IDLE,
        BURST
    } arb_state_e;

    typedef logic [W_DATA-1:0] word_t;
endpackage

// File: rtl/sdp_dc_ram_pkg.sv
// Shared storage parameters for the single-clock FIFO RAM.
package sdp_dc_ram_pkg;
    localparam int W_DATA = 32;
endpackage

// File: rtl/fifo_push_arbiter_if.sv
// Producer-side req/gnt bundle plus the FIFO push/data/full strobe group.
interface fifo_push_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = 16
);
    logic [N_REQ-1:0] req;
    word_t            wr_data [N_REQ];
    logic [N_REQ-1:0] gnt;
    logic             push;
    word_t            data;
    logic             full;
    logic [CNT_W-1:0] grant_cnt [N_REQ];

    modport master (
        output req, wr_data, full,
        input  gnt, push, data, grant_cnt
    );

    modport slave (
        input  req, wr_data, full,
        output gnt, push, data, grant_cnt
    );
endinterface

// File: rtl/fifo_push_arbiter_rr_select.sv
// First set request bit at or after a rotating start index, wrapping mod N_REQ.
module rr_select #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    start,
    output logic             valid,
    output logic [IW-1:0]    idx
);
    // Scan from farthest to nearest so the nearest hit wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            int j;
            j = (int'(start) + k) % N_REQ;
            if (req[j]) begin
                valid = 1'b1;
                idx   = IW'(j);
            end
        end
    end
endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the FIFO push port among producers.
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    fifo_push_arbiter_if.slave bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BW = $clog2(BURST_LEN + 1);

    if (N_REQ < 2 || N_REQ > N_REQ_MAX) begin : g_bad_n
        $error("N_REQ out of range");
    end
    if (BURST_LEN < 1 || BURST_LEN > BURST_LEN_MAX) begin : g_bad_b
        $error("BURST_LEN out of range");
    end

    arb_state_e       state;
    logic [IW-1:0]    owner;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    start;
    logic [IW-1:0]    sel_idx;
    logic [IW-1:0]    gnt_idx;
    logic [BW-1:0]    burst_cnt;
    logic [BW-1:0]    burst_nxt;
    logic             sel_valid;
    logic             release_own;
    logic             own_go;
    logic             idle_go;
    logic             gnt_any;
    logic [N_REQ-1:0] gnt;
    logic [CNT_W-1:0] cnt_q [N_REQ];

    function automatic logic [IW-1:0] inc(input logic [IW-1:0] i);
        return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    // An owner that drops req hands over in the same cycle.
    assign release_own = (state == BURST) && !bus.req[owner];
    assign start       = release_own ? inc(owner) : rr_ptr;

    rr_select #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_sel (
        .req   (bus.req),
        .start (start),
        .valid (sel_valid),
        .idx   (sel_idx)
    );

    assign own_go    = (state == BURST) && bus.req[owner] && !bus.full;
    assign idle_go   = ((state == IDLE) || release_own) && sel_valid && !bus.full;
    assign gnt_any   = rst && (own_go || idle_go);
    assign gnt_idx   = own_go ? owner : sel_idx;
    assign burst_nxt = burst_cnt + 1'b1;

    always_comb begin
        gnt = '0;
        if (gnt_any) gnt[gnt_idx] = 1'b1;
    end

    assign bus.gnt       = gnt;
    assign bus.push      = gnt_any;
    assign bus.data      = gnt_any ? bus.wr_data[gnt_idx] : '0;
    assign bus.grant_cnt = cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
        end else begin
            if (own_go) begin
                if (burst_nxt == BW'(BURST_LEN)) begin
                    rr_ptr    <= inc(owner);
                    state     <= IDLE;
                    burst_cnt <= '0;
                end else begin
                    burst_cnt <= burst_nxt;
                end
            end else if (state == BURST && bus.full) begin
                state <= BURST;
            end else begin
                if (release_own) begin
                    rr_ptr    <= inc(owner);
                    state     <= IDLE;
                    burst_cnt <= '0;
                end
                if (idle_go) begin
                    owner <= sel_idx;
                    if (BURST_LEN == 1) begin
                        rr_ptr    <= inc(sel_idx);
                        state     <= IDLE;
                        burst_cnt <= '0;
                    end else begin
                        state     <= BURST;
                        burst_cnt <= BW'(1);
                    end
                end
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (gnt[i]) cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed-vector bench for the FIFO push arbiter with a FIFO order scoreboard.
module tb_fifo_push_arbiter;
    import fifo_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fifo_push_arbiter_if #(.N_REQ(4), .CNT_W(16)) bus ();

    fifo_push_arbiter #(
        .N_REQ     (4),
        .BURST_LEN (4),
        .CNT_W     (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    n_run  = 0;
    int    n_fail = 0;
    int    exp_cnt [4];
    word_t fifo_q [$];
    word_t exp_q  [$];

    function automatic word_t word(input int i);
        return word_t'(32'hC0DE_0000 + 32'(i));
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_cnt(input string tag);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s[%0d]", tag, i), 64'(bus.grant_cnt[i]), 64'(exp_cnt[i]));
    endtask

    // Drive one cycle, check the combinational grant, advance past the edge.
    task automatic cyc(input logic [3:0] r, input logic f, input logic [3:0] eg);
        bus.req  = r;
        bus.full = f;
        @(negedge clk);
        chk("gnt", 64'(bus.gnt), 64'(eg));
        chk("push", 64'(bus.push), 64'(|eg));
        for (int i = 0; i < 4; i++) begin
            if (eg[i]) begin
                chk("data", 64'(bus.data), 64'(word(i)));
                exp_q.push_back(word(i));
                exp_cnt[i]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && bus.push === 1'b1) fifo_q.push_back(bus.data);
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            bus.wr_data[i] = word(i);
            exp_cnt[i]     = 0;
        end
        rst      = 1'b0;
        bus.req  = 4'b1111;
        bus.full = 1'b0;

        @(negedge clk);
        chk("rst_gnt", 64'(bus.gnt), 64'h0);
        chk("rst_push", 64'(bus.push), 64'h0);
        chk("rst_data", 64'(bus.data), 64'h0);
        chk_cnt("rst_cnt");
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int k = 0; k < 16; k++) cyc(4'b1111, 1'b0, 4'(1 << (k / 4)));
        chk_cnt("rr_cnt");

        repeat (10) cyc(4'b0100, 1'b0, 4'b0100);
        chk_cnt("single_cnt");

        cyc(4'b0000, 1'b0, 4'b0000);

        repeat (2) cyc(4'b0110, 1'b0, 4'b0010);
        repeat (3) cyc(4'b0110, 1'b1, 4'b0000);
        repeat (2) cyc(4'b0110, 1'b0, 4'b0010);
        cyc(4'b0110, 1'b0, 4'b0100);

        cyc(4'b1000, 1'b0, 4'b1000);
        cyc(4'b0001, 1'b0, 4'b0001);
        cyc(4'b0001, 1'b0, 4'b0001);
        chk_cnt("pre_rst_cnt");

        rst = 1'b0;
        #1;
        chk("mid_rst_gnt", 64'(bus.gnt), 64'h0);
        chk("mid_rst_push", 64'(bus.push), 64'h0);
        chk("mid_rst_data", 64'(bus.data), 64'h0);
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
        chk_cnt("mid_rst_cnt");
        @(posedge clk);
        #1;
        rst = 1'b1;

        cyc(4'b0011, 1'b0, 4'b0001);
        cyc(4'b0010, 1'b0, 4'b0010);
        chk_cnt("post_rst_cnt");

        chk("fifo_len", 64'(fifo_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < fifo_q.size())
                chk($sformatf("fifo_word%0d", i), 64'(fifo_q[i]), 64'(exp_q[i]));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
